// File: rtl/aes128_inv_cipher.sv
// aes128_inv_cipher: iterative AES-128 decryption, one round per clock.
// Key schedule expands forward once at key load, then unwinds per block.
module aes128_inv_cipher (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         key_valid,
    input  logic [127:0] key_in,
    output logic         key_ready,
    input  logic         in_valid,
    input  logic [127:0] ct_in,
    output logic         in_ready,
    output logic         out_valid,
    output logic [127:0] pt_out,
    input  logic         out_ready
);

    localparam logic [2047:0] SBOX = {
        256'h637c777bf26b6fc53001672bfed7ab76_ca82c97dfa5947f0add4a2af9ca472c0,
        256'hb7fd9326363ff7cc34a5e5f171d83115_04c723c31896059a071280e2eb27b275,
        256'h09832c1a1b6e5aa0523bd6b329e32f84_53d100ed20fcb15b6acbbe394a4c58cf,
        256'hd0efaafb434d338545f9027f503c9fa8_51a3408f929d38f5bcb6da2110fff3d2,
        256'hcd0c13ec5f974417c4a77e3d645d1973_60814fdc222a908846eeb814de5e0bdb,
        256'he0323a0a4906245cc2d3ac629195e479_e7c8376d8dd54ea96c56f4ea657aae08,
        256'hba78252e1ca6b4c6e8dd741f4bbd8b8a_703eb5664803f60e613557b986c11d9e,
        256'he1f8981169d98e949b1e87e9ce5528df_8ca1890dbfe6426841992d0fb054bb16
    };

    localparam logic [2047:0] INV_SBOX = {
        256'h52096ad53036a538bf40a39e81f3d7fb_7ce339829b2fff87348e4344c4dee9cb,
        256'h547b9432a6c2233dee4c950b42fac34e_082ea16628d924b2765ba2496d8bd125,
        256'h72f8f66486689816d4a45ccc5d65b692_6c704850fdedb9da5e154657a78d9d84,
        256'h90d8ab008cbcd30af7e45805b8b34506_d02c1e8fca3f0f02c1afbd0301138a6b,
        256'h3a9111414f67dcea97f2cfcef0b4e673_96ac7422e7ad3585e2f937e81c75df6e,
        256'h47f11a711d29c5896fb7620eaa18be1b_fc563e4bc6d279209adbc0fe78cd5af4,
        256'h1fdda8338807c731b11210592780ec5f_60517fa919b54a0d2de57a9f93c99cef,
        256'ha0e03b4dae2af5b0c8ebbb3c83539961_172b047eba77d626e169146355210c7d
    };

    typedef enum logic [2:0] {
        S_NOKEY,
        S_KEXP,
        S_IDLE,
        S_ROUND,
        S_HOLD
    } state_t;

    state_t       r_fsm;
    state_t       w_fsm_nxt;
    logic [127:0] r_rk0;
    logic [127:0] r_rk10;
    logic [127:0] r_key;
    logic [127:0] r_st;
    logic [3:0]   r_cnt;
    logic [7:0]   w_rc;
    logic [127:0] w_rk_next;
    logic [127:0] w_rk_prev;
    logic [127:0] w_isb;
    logic [127:0] w_ark;
    logic [127:0] w_round;

    // Table entry x sits at bits [2047-8x -: 8], i.e. {~x, 3'b111}.
    function automatic logic [7:0] sb(input logic [7:0] x);
        return SBOX[{~x, 3'b111} -: 8];
    endfunction

    function automatic logic [7:0] isb(input logic [7:0] x);
        return INV_SBOX[{~x, 3'b111} -: 8];
    endfunction

    function automatic logic [7:0] xt(input logic [7:0] x);
        return {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [31:0] inv_mix_col(input logic [31:0] col);
        logic [7:0] m9 [4];
        logic [7:0] mb [4];
        logic [7:0] md [4];
        logic [7:0] me [4];
        logic [7:0] a1, a2, a4, a8;
        for (int i = 0; i < 4; i++) begin
            a1 = col[31-8*i -: 8];
            a2 = xt(a1);
            a4 = xt(a2);
            a8 = xt(a4);
            m9[i] = a8 ^ a1;
            mb[i] = a8 ^ a2 ^ a1;
            md[i] = a8 ^ a4 ^ a1;
            me[i] = a8 ^ a4 ^ a2;
        end
        return {me[0] ^ mb[1] ^ md[2] ^ m9[3],
                m9[0] ^ me[1] ^ mb[2] ^ md[3],
                md[0] ^ m9[1] ^ me[2] ^ mb[3],
                mb[0] ^ md[1] ^ m9[2] ^ me[3]};
    endfunction

    function automatic logic [31:0] sub_rot(input logic [31:0] w);
        return {sb(w[23:16]), sb(w[15:8]), sb(w[7:0]), sb(w[31:24])};
    endfunction

    function automatic logic [127:0] key_fwd(
        input logic [127:0] k,
        input logic [7:0]   rc
    );
        logic [31:0] t, n0, n1, n2, n3;
        t  = sub_rot(k[31:0]) ^ {rc, 24'h0};
        n0 = k[127:96] ^ t;
        n1 = k[95:64] ^ n0;
        n2 = k[63:32] ^ n1;
        n3 = k[31:0] ^ n2;
        return {n0, n1, n2, n3};
    endfunction

    // Undo one expansion step: words 1..3 first, then word 0 via the new word 3.
    function automatic logic [127:0] key_inv(
        input logic [127:0] k,
        input logic [7:0]   rc
    );
        logic [31:0] p0, p1, p2, p3;
        p3 = k[31:0] ^ k[63:32];
        p2 = k[63:32] ^ k[95:64];
        p1 = k[95:64] ^ k[127:96];
        p0 = k[127:96] ^ sub_rot(p3) ^ {rc, 24'h0};
        return {p0, p1, p2, p3};
    endfunction

    function automatic logic [7:0] rcon(input logic [3:0] n);
        logic [7:0] v;
        v = 8'h00;
        case (n)
            4'd0:    v = 8'h01;
            4'd1:    v = 8'h02;
            4'd2:    v = 8'h04;
            4'd3:    v = 8'h08;
            4'd4:    v = 8'h10;
            4'd5:    v = 8'h20;
            4'd6:    v = 8'h40;
            4'd7:    v = 8'h80;
            4'd8:    v = 8'h1b;
            4'd9:    v = 8'h36;
            default: v = 8'h00;
        endcase
        return v;
    endfunction

    assign w_rc      = rcon(r_cnt);
    assign w_rk_next = key_fwd(r_key, w_rc);
    assign w_rk_prev = key_inv(r_key, w_rc);

    // InvShiftRows folded into the InvSubBytes gather.
    always_comb begin
        w_isb = '0;
        for (int c = 0; c < 4; c++) begin
            for (int r = 0; r < 4; r++) begin
                w_isb[127-8*(r+4*c) -: 8] =
                    isb(r_st[127-8*(r+4*((c+4-r)%4)) -: 8]);
            end
        end
    end

    assign w_ark = w_isb ^ ((r_cnt == 4'd0) ? r_rk0 : w_rk_prev);

    always_comb begin
        w_round = w_ark;
        if (r_cnt != 4'd0) begin
            for (int c = 0; c < 4; c++) begin
                w_round[127-32*c -: 32] = inv_mix_col(w_ark[127-32*c -: 32]);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_fsm <= S_NOKEY;
        end else begin
            r_fsm <= w_fsm_nxt;
        end
    end

    always_comb begin
        w_fsm_nxt = r_fsm;
        key_ready = 1'b0;
        in_ready  = 1'b0;
        out_valid = 1'b0;
        unique case (r_fsm)
            S_NOKEY: begin
                key_ready = 1'b1;
                if (key_valid) w_fsm_nxt = S_KEXP;
            end
            S_KEXP: begin
                if (r_cnt == 4'd9) w_fsm_nxt = S_IDLE;
            end
            S_IDLE: begin
                key_ready = 1'b1;
                in_ready  = !key_valid;
                if (key_valid)     w_fsm_nxt = S_KEXP;
                else if (in_valid) w_fsm_nxt = S_ROUND;
            end
            S_ROUND: begin
                if (r_cnt == 4'd0) w_fsm_nxt = S_HOLD;
            end
            S_HOLD: begin
                out_valid = 1'b1;
                if (out_ready) w_fsm_nxt = S_IDLE;
            end
            default: w_fsm_nxt = S_NOKEY;
        endcase
    end

    assign pt_out = out_valid ? r_st : '0;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_rk0  <= '0;
            r_rk10 <= '0;
            r_key  <= '0;
            r_st   <= '0;
            r_cnt  <= '0;
        end else begin
            unique case (r_fsm)
                S_NOKEY: begin
                    if (key_valid) begin
                        r_rk0 <= key_in;
                        r_key <= key_in;
                        r_cnt <= 4'd0;
                    end
                end
                S_KEXP: begin
                    r_key <= w_rk_next;
                    r_cnt <= r_cnt + 4'd1;
                    if (r_cnt == 4'd9) r_rk10 <= w_rk_next;
                end
                S_IDLE: begin
                    if (key_valid) begin
                        r_rk0 <= key_in;
                        r_key <= key_in;
                        r_cnt <= 4'd0;
                    end else if (in_valid) begin
                        r_st  <= ct_in ^ r_rk10;
                        r_key <= r_rk10;
                        r_cnt <= 4'd9;
                    end
                end
                S_ROUND: begin
                    r_st  <= w_round;
                    r_key <= w_rk_prev;
                    r_cnt <= r_cnt - 4'd1;
                end
                default: begin
                end
            endcase
        end
    end

endmodule

// File: tb/tb_aes128_inv_cipher.sv
// tb_aes128_inv_cipher: known-answer vectors, handshake corner cases and
// a random scoreboard against a byte-level AES-128 encryption model.
module tb_aes128_inv_cipher;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         key_valid;
    logic [127:0] key_in;
    logic         key_ready;
    logic         in_valid;
    logic [127:0] ct_in;
    logic         in_ready;
    logic         out_valid;
    logic [127:0] pt_out;
    logic         out_ready;

    always #5 clk = ~clk;

    aes128_inv_cipher dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .key_valid (key_valid),
        .key_in    (key_in),
        .key_ready (key_ready),
        .in_valid  (in_valid),
        .ct_in     (ct_in),
        .in_ready  (in_ready),
        .out_valid (out_valid),
        .pt_out    (pt_out),
        .out_ready (out_ready)
    );

    int n_cmp = 0;
    int n_bad = 0;

    logic [7:0] m_sb [256];

    typedef struct {
        logic [127:0] key;
        logic [127:0] ct;
        logic [127:0] pt;
        logic [127:0] rk10;
    } vec_t;

    vec_t vecs [4];

    task automatic chk(input string nm, input logic [127:0] got,
                       input logic [127:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", nm, got, exp);
        end
    endtask

    task automatic chk1(input string nm, input logic got, input logic exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %b expected %b", nm, got, exp);
        end
    endtask

    task automatic chkn(input string nm, input int got, input int exp);
        n_cmp++;
        if (got != exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d", nm, got, exp);
        end
    endtask

    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p, x;
        p = 8'h00;
        x = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) p = p ^ x;
            x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
        end
        return p;
    endfunction

    // S-box from its definition: multiplicative inverse then affine map.
    task automatic build_sbox();
        logic [7:0] x, inv, s;
        for (int v = 0; v < 256; v++) begin
            x   = 8'(v);
            inv = 8'h00;
            for (int y = 1; y < 256; y++) begin
                if (gmul(x, 8'(y)) == 8'h01) inv = 8'(y);
            end
            s = inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]}
                    ^ {inv[4:0], inv[7:5]} ^ {inv[3:0], inv[7:4]};
            m_sb[v] = s ^ 8'h63;
        end
    endtask

    function automatic logic [127:0] ref_rk(input logic [127:0] key, input int r);
        logic [31:0] w [44];
        logic [31:0] t;
        logic [7:0]  rc;
        for (int i = 0; i < 4; i++) w[i] = key[127-32*i -: 32];
        rc = 8'h01;
        for (int i = 4; i < 44; i++) begin
            t = w[i-1];
            if (i % 4 == 0) begin
                t = {t[23:0], t[31:24]};
                t = {m_sb[t[31:24]], m_sb[t[23:16]], m_sb[t[15:8]], m_sb[t[7:0]]}
                    ^ {rc, 24'h0};
                rc = gmul(rc, 8'h02);
            end
            w[i] = w[i-4] ^ t;
        end
        return {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};
    endfunction

    function automatic logic [127:0] ref_enc(input logic [127:0] key,
                                             input logic [127:0] pt);
        logic [7:0]   s [16];
        logic [7:0]   t [16];
        logic [7:0]   a0, a1, a2, a3;
        logic [127:0] rk, res;
        for (int i = 0; i < 16; i++) s[i] = pt[127-8*i -: 8] ^ key[127-8*i -: 8];
        for (int rnd = 1; rnd <= 10; rnd++) begin
            for (int i = 0; i < 16; i++)
                t[i] = m_sb[s[(i % 4) + 4 * (((i / 4) + (i % 4)) % 4)]];
            if (rnd < 10) begin
                for (int c = 0; c < 4; c++) begin
                    a0 = t[4*c]; a1 = t[4*c+1]; a2 = t[4*c+2]; a3 = t[4*c+3];
                    s[4*c]   = gmul(a0, 8'h02) ^ gmul(a1, 8'h03) ^ a2 ^ a3;
                    s[4*c+1] = a0 ^ gmul(a1, 8'h02) ^ gmul(a2, 8'h03) ^ a3;
                    s[4*c+2] = a0 ^ a1 ^ gmul(a2, 8'h02) ^ gmul(a3, 8'h03);
                    s[4*c+3] = gmul(a0, 8'h03) ^ a1 ^ a2 ^ gmul(a3, 8'h02);
                end
            end else begin
                for (int i = 0; i < 16; i++) s[i] = t[i];
            end
            rk = ref_rk(key, rnd);
            for (int i = 0; i < 16; i++) s[i] = s[i] ^ rk[127-8*i -: 8];
        end
        for (int i = 0; i < 16; i++) res[127-8*i -: 8] = s[i];
        return res;
    endfunction

    function automatic logic [127:0] rnd128();
        return {$urandom, $urandom, $urandom, $urandom};
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic load_key(input logic [127:0] k);
        int n;
        int early;
        n = 0;
        while (!key_ready && n < 40) begin
            step();
            n++;
        end
        chk1("key_ready_wait", key_ready, 1'b1);
        key_valid = 1'b1;
        key_in    = k;
        step();
        key_valid = 1'b0;
        chk1("kexp_key_ready", key_ready, 1'b0);
        early = 0;
        for (int i = 1; i < 10; i++) begin
            step();
            if (in_ready) early++;
        end
        chkn("kexp_in_ready_early", early, 0);
        step();
        chk1("kexp_in_ready_t10", in_ready, 1'b1);
    endtask

    task automatic send_ct(input logic [127:0] c, output int lat);
        int n;
        n = 0;
        while (!in_ready && n < 40) begin
            step();
            n++;
        end
        chk1("in_ready_wait", in_ready, 1'b1);
        in_valid = 1'b1;
        ct_in    = c;
        step();
        in_valid = 1'b0;
        lat = 0;
        while (!out_valid && lat < 40) begin
            step();
            lat++;
        end
    endtask

    initial begin
        #10_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        logic [127:0] cur_key, kb, p, c;
        int lat, nbad, n;
        logic seen, done;

        build_sbox();
        rst_n     = 1'b0;
        key_valid = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b1;
        key_in    = '0;
        ct_in     = '0;
        repeat (3) step();
        chk1("rst_key_ready", key_ready, 1'b1);
        chk1("rst_in_ready", in_ready, 1'b0);
        chk1("rst_out_valid", out_valid, 1'b0);
        chk("rst_pt_out", pt_out, 128'h0);
        chk("rst_rk10", dut.r_rk10, 128'h0);
        rst_n = 1'b1;
        step();
        chk1("nokey_in_ready", in_ready, 1'b0);

        vecs[0] = '{128'h000102030405060708090a0b0c0d0e0f,
                    128'h69c4e0d86a7b0430d8cdb78070b4c55a,
                    128'h00112233445566778899aabbccddeeff,
                    128'h13111d7fe3944a17f307a78b4d2b30c5};
        vecs[1] = '{128'h2b7e151628aed2a6abf7158809cf4f3c,
                    128'h3925841d02dc09fbdc118597196a0b32,
                    128'h3243f6a8885a308d313198a2e0370734,
                    128'hd014f9a8c9ee2589e13f0cc8b6630ca6};
        vecs[2] = vecs[0];
        vecs[3] = '{128'h0,
                    128'h66e94bd4ef8a2c3b884cfa59ca342b2e,
                    128'h0,
                    ref_rk(128'h0, 10)};

        for (int i = 0; i < 4; i++) begin
            load_key(vecs[i].key);
            chk($sformatf("v%0d_rk10", i), dut.r_rk10, vecs[i].rk10);
            send_ct(vecs[i].ct, lat);
            chk($sformatf("v%0d_pt", i), pt_out, vecs[i].pt);
            chkn($sformatf("v%0d_latency", i), lat, 10);
            step();
            chk1($sformatf("v%0d_ov_drop", i), out_valid, 1'b0);
            chk1($sformatf("v%0d_in_ready", i), in_ready, 1'b1);
        end
        cur_key = vecs[3].key;

        out_ready = 1'b0;
        p = rnd128();
        c = ref_enc(cur_key, p);
        send_ct(c, lat);
        chk("bp_pt", pt_out, p);
        nbad = 0;
        for (int i = 0; i < 20; i++) begin
            in_valid = (i % 2 == 1);
            ct_in    = rnd128();
            step();
            if (!out_valid || pt_out !== p || in_ready) nbad++;
        end
        chkn("bp_hold_stable", nbad, 0);
        in_valid  = 1'b0;
        out_ready = 1'b1;
        step();
        chk1("bp_release_ov", out_valid, 1'b0);
        chk1("bp_release_in_ready", in_ready, 1'b1);

        kb = rnd128();
        p  = rnd128();
        c  = ref_enc(kb, p);
        key_valid = 1'b1;
        key_in    = kb;
        in_valid  = 1'b1;
        ct_in     = c;
        #1;
        chk1("sim_in_ready", in_ready, 1'b0);
        chk1("sim_key_ready", key_ready, 1'b1);
        step();
        key_valid = 1'b0;
        in_valid  = 1'b0;
        chk1("sim_kexp_key_ready", key_ready, 1'b0);
        n = 0;
        while (!in_ready && n < 40) begin
            step();
            n++;
        end
        chkn("sim_kexp_len", n, 10);
        chk("sim_rk10", dut.r_rk10, ref_rk(kb, 10));
        send_ct(c, lat);
        chk("sim_pt", pt_out, p);
        step();
        cur_key = kb;

        p = rnd128();
        c = ref_enc(cur_key, p);
        chk1("mid_in_ready", in_ready, 1'b1);
        in_valid = 1'b1;
        ct_in    = c;
        step();
        in_valid = 1'b0;
        repeat (5) step();
        rst_n = 1'b0;
        step();
        rst_n = 1'b1;
        chk1("mid_rst_out_valid", out_valid, 1'b0);
        chk1("mid_rst_key_ready", key_ready, 1'b1);
        chk1("mid_rst_in_ready", in_ready, 1'b0);
        chk("mid_rst_rk10", dut.r_rk10, 128'h0);
        nbad = 0;
        in_valid = 1'b1;
        for (int i = 0; i < 15; i++) begin
            step();
            if (in_ready || out_valid) nbad++;
        end
        chkn("mid_rst_ignore_in", nbad, 0);
        in_valid = 1'b0;
        load_key(cur_key);
        send_ct(c, lat);
        chk("mid_rst_reload_pt", pt_out, p);
        step();

        for (int t = 0; t < 1000; t++) begin
            kb = rnd128();
            p  = rnd128();
            c  = ref_enc(kb, p);
            load_key(kb);
            out_ready = 1'($urandom_range(0, 1));
            in_valid  = 1'b1;
            ct_in     = c;
            step();
            in_valid = 1'b0;
            seen = 1'b0;
            done = 1'b0;
            n = 0;
            while (!done && n < 200) begin
                if (out_valid) begin
                    if (!seen) chkn("rnd_latency", n, 10);
                    seen = 1'b1;
                    chk("rnd_pt", pt_out, p);
                end
                out_ready = 1'($urandom_range(0, 1));
                if (out_valid && out_ready) done = 1'b1;
                step();
                n++;
            end
            chk1("rnd_done", done, 1'b1);
            chk1("rnd_ov_drop", out_valid, 1'b0);
            out_ready = 1'b1;
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
